// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM burst arbiter: engine command codes, FSM states
// and the burst-alignment helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_REFRESH = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_READ    = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    S_WAIT_INIT = 2'b00,
    S_ARB       = 2'b01,
    S_ISSUE     = 2'b10,
    S_WAIT_DONE = 2'b11
  } state_t;

  // Number of low address bits cleared to align a burst start address.
  function automatic int burst_shift(input int burst_len);
    return $clog2(burst_len);
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh period counter with a saturating queue of owed refreshes and a
// sticky overrun flag raised when a tick finds the queue already full.
module sdram_refresh_timer #(
  parameter int REF_PERIOD  = 780,
  parameter int REF_MAXPEND = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic enable,
  input  logic refresh_issued,
  output logic pend_nz,
  output logic overrun
);

  localparam int CW = $clog2(REF_PERIOD);
  localparam int PW = $clog2(REF_MAXPEND + 1);

  logic [CW-1:0] count_reg;
  logic [PW-1:0] pend_reg;
  logic          overrun_reg;
  logic          tick;

  assign tick    = enable && (count_reg == CW'(REF_PERIOD - 1));
  assign pend_nz = (pend_reg != '0);
  assign overrun = overrun_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg   <= '0;
      pend_reg    <= '0;
      overrun_reg <= 1'b0;
    end else if (!enable) begin
      // Leaving init clears the schedule; the overrun flag survives until reset.
      count_reg <= '0;
      pend_reg  <= '0;
    end else begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
      if (tick && !refresh_issued) begin
        if (pend_reg == PW'(REF_MAXPEND))
          overrun_reg <= 1'b1;
        else
          pend_reg <= pend_reg + PW'(1);
      end else if (!tick && refresh_issued && pend_reg != '0) begin
        pend_reg <= pend_reg - PW'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Schedules refresh, write-burst and read-burst commands to the SDRAM command
// engine one at a time and reports per-burst completion.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int BURST_LEN   = 8,
  parameter int REF_PERIOD  = 780,
  parameter int REF_MAXPEND = 3
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              INIT_DONE,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              CMD_VALID,
  output logic [1:0]        CMD_TYPE,
  output logic [ADDR_W-1:0] CMD_ADDR,
  input  logic              CMD_READY,
  input  logic              CMD_DONE,
  output logic              WR_BURST_DONE,
  output logic              RD_BURST_DONE,
  output logic              BUSY,
  output logic              REF_OVERRUN
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~((ADDR_W'(1) << burst_shift(BURST_LEN)) - ADDR_W'(1));

  state_t            state_reg, state_next;
  cmd_t              cmd_type_reg, cmd_type_next;
  logic [ADDR_W-1:0] cmd_addr_reg, cmd_addr_next;
  logic              prio_write_reg, prio_write_next;
  logic              wr_done_reg, rd_done_reg;
  logic              pend_nz, overrun, grant, arb_live, accept;

  assign accept   = (state_reg == S_ISSUE) && CMD_READY;
  assign arb_live = (state_reg == S_ARB) && INIT_DONE;

  sdram_refresh_timer #(
    .REF_PERIOD (REF_PERIOD),
    .REF_MAXPEND(REF_MAXPEND)
  ) u_refresh_timer (
    .clk           (SYSCLK),
    .srst          (RST),
    .enable        (state_reg != S_WAIT_INIT),
    .refresh_issued(accept && (cmd_type_reg == CMD_REFRESH)),
    .pend_nz       (pend_nz),
    .overrun       (overrun)
  );

  // prio_write names the side favoured next when both bursts are requested.
  always_comb begin
    grant           = 1'b0;
    cmd_type_next   = cmd_type_reg;
    cmd_addr_next   = cmd_addr_reg;
    prio_write_next = prio_write_reg;
    if (arb_live) begin
      if (pend_nz) begin
        grant         = 1'b1;
        cmd_type_next = CMD_REFRESH;
        cmd_addr_next = '0;
      end else if (WR_REQ && (!RD_REQ || prio_write_reg)) begin
        grant           = 1'b1;
        cmd_type_next   = CMD_WRITE;
        cmd_addr_next   = WR_ADDR & ALIGN_MASK;
        prio_write_next = 1'b0;
      end else if (RD_REQ) begin
        grant           = 1'b1;
        cmd_type_next   = CMD_READ;
        cmd_addr_next   = RD_ADDR & ALIGN_MASK;
        prio_write_next = 1'b1;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) state_reg <= S_WAIT_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT_INIT: if (INIT_DONE) state_next = S_ARB;
      S_ARB: begin
        if (!INIT_DONE)  state_next = S_WAIT_INIT;
        else if (grant)  state_next = S_ISSUE;
      end
      S_ISSUE:     if (CMD_READY) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (CMD_DONE)  state_next = INIT_DONE ? S_ARB : S_WAIT_INIT;
      default:     state_next = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      cmd_type_reg   <= CMD_NOP;
      cmd_addr_reg   <= '0;
      prio_write_reg <= 1'b1;
      wr_done_reg    <= 1'b0;
      rd_done_reg    <= 1'b0;
    end else begin
      cmd_type_reg   <= cmd_type_next;
      cmd_addr_reg   <= cmd_addr_next;
      prio_write_reg <= prio_write_next;
      wr_done_reg    <= (state_reg == S_WAIT_DONE) && CMD_DONE && (cmd_type_reg == CMD_WRITE);
      rd_done_reg    <= (state_reg == S_WAIT_DONE) && CMD_DONE && (cmd_type_reg == CMD_READ);
    end
  end

  always_comb begin
    CMD_VALID = 1'b0;
    CMD_TYPE  = CMD_NOP;
    CMD_ADDR  = '0;
    BUSY      = 1'b0;
    case (state_reg)
      S_ISSUE: begin
        CMD_VALID = 1'b1;
        CMD_TYPE  = cmd_type_reg;
        CMD_ADDR  = cmd_addr_reg;
        BUSY      = 1'b1;
      end
      S_WAIT_DONE: BUSY = 1'b1;
      default: ;
    endcase
  end

  assign WR_BURST_DONE = wr_done_reg;
  assign RD_BURST_DONE = rd_done_reg;
  assign REF_OVERRUN   = overrun;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter: init gating, write burst, round robin,
// refresh priority and period, refresh overrun, backpressure and mid-command reset.
module tb_sdram_burst_arbiter;

  localparam int ADDR_W = 22;

  logic              SYSCLK = 1'b0;
  logic              RST, INIT_DONE, WR_REQ, RD_REQ, CMD_READY, CMD_DONE;
  logic [ADDR_W-1:0] WR_ADDR, RD_ADDR, CMD_ADDR;
  logic              CMD_VALID, WR_BURST_DONE, RD_BURST_DONE, BUSY, REF_OVERRUN;
  logic [1:0]        CMD_TYPE;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  sdram_burst_arbiter #(
    .ADDR_W(22), .BURST_LEN(8), .REF_PERIOD(780), .REF_MAXPEND(3)
  ) dut (
    .SYSCLK(SYSCLK), .RST(RST), .INIT_DONE(INIT_DONE),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
    .CMD_READY(CMD_READY), .CMD_DONE(CMD_DONE),
    .WR_BURST_DONE(WR_BURST_DONE), .RD_BURST_DONE(RD_BURST_DONE),
    .BUSY(BUSY), .REF_OVERRUN(REF_OVERRUN)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic step();
    @(posedge SYSCLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1; INIT_DONE = 1'b0; WR_REQ = 1'b0; RD_REQ = 1'b0;
    WR_ADDR = '0; RD_ADDR = '0; CMD_READY = 1'b0; CMD_DONE = 1'b0;
    repeat (4) step();
    RST = 1'b0;
  endtask

  // Returns the cycle number of the first cycle spent in ARB.
  task automatic do_init(output int t0);
    do_reset();
    INIT_DONE = 1'b1;
    step();
    t0 = cyc;
  endtask

  // Engine model: accept the next command, finish it dly cycles after acceptance.
  task automatic serve(input int dly, input int budget, output logic [1:0] typ,
                       output logic [ADDR_W-1:0] adr, output bit ok);
    ok = 1'b0; typ = 2'b00; adr = '0;
    CMD_READY = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (CMD_VALID) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      CMD_READY = 1'b0;
      return;
    end
    typ = CMD_TYPE;
    adr = CMD_ADDR;
    step();
    CMD_READY = 1'b0;
    repeat (dly - 1) step();
    CMD_DONE = 1'b1;
    step();
    CMD_DONE = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    do_reset();
    WR_REQ = 1'b1; WR_ADDR = 22'h000013;
    checks++;
    if ({CMD_VALID, CMD_TYPE, CMD_ADDR, BUSY, WR_BURST_DONE, RD_BURST_DONE, REF_OVERRUN} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b type=%b addr=%h busy=%b wrd=%b rdd=%b ovr=%b, expected all 0",
               CMD_VALID, CMD_TYPE, CMD_ADDR, BUSY, WR_BURST_DONE, RD_BURST_DONE, REF_OVERRUN);
    end
    seen = 0;
    repeat (100) begin
      step();
      if (CMD_VALID || BUSY) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL no_cmd_before_init: %0d active cycles, expected 0", seen);
    end
    INIT_DONE = 1'b1;
    step();
    checks++;
    if (CMD_VALID !== 1'b0) begin
      fails++;
      $display("FAIL init_latency_n1: valid=%b, expected 0", CMD_VALID);
    end
    step();
    checks++;
    if (CMD_VALID !== 1'b1 || CMD_TYPE !== 2'b10) begin
      fails++;
      $display("FAIL init_latency_n2: valid=%b type=%b, expected 1/10", CMD_VALID, CMD_TYPE);
    end
  endtask

  task automatic test_write_burst();
    int t0;
    do_init(t0);
    WR_REQ = 1'b1; WR_ADDR = 22'h000013; CMD_READY = 1'b1;
    step();
    checks++;
    if (CMD_VALID !== 1'b1 || CMD_TYPE !== 2'b10 || CMD_ADDR !== 22'h000010 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL write_issue: valid=%b type=%b addr=%h busy=%b, expected 1/10/000010/1",
               CMD_VALID, CMD_TYPE, CMD_ADDR, BUSY);
    end
    step();
    CMD_READY = 1'b0; WR_REQ = 1'b0;
    checks++;
    if (CMD_VALID !== 1'b0 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL write_valid_drop: valid=%b busy=%b, expected 0/1", CMD_VALID, BUSY);
    end
    repeat (9) step();
    CMD_DONE = 1'b1;
    checks++;
    if (WR_BURST_DONE !== 1'b0) begin
      fails++;
      $display("FAIL write_done_early: wr_burst_done=%b, expected 0", WR_BURST_DONE);
    end
    step();
    CMD_DONE = 1'b0;
    checks++;
    if (WR_BURST_DONE !== 1'b1 || RD_BURST_DONE !== 1'b0 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL write_done_pulse: wrd=%b rdd=%b busy=%b, expected 1/0/0",
               WR_BURST_DONE, RD_BURST_DONE, BUSY);
    end
    step();
    checks++;
    if (WR_BURST_DONE !== 1'b0 || BUSY !== 1'b0 || CMD_VALID !== 1'b0) begin
      fails++;
      $display("FAIL write_done_single: wrd=%b busy=%b valid=%b, expected 0/0/0",
               WR_BURST_DONE, BUSY, CMD_VALID);
    end
  endtask

  task automatic test_round_robin();
    int t0;
    bit ok;
    logic [1:0] typ;
    logic [ADDR_W-1:0] adr, exp_a;
    logic [1:0] exp_t [4];
    exp_t = '{2'b10, 2'b11, 2'b10, 2'b11};
    do_init(t0);
    WR_REQ = 1'b1; RD_REQ = 1'b1;
    WR_ADDR = 22'h000100; RD_ADDR = 22'h00020F;
    for (int i = 0; i < 4; i++) begin
      serve(3, 20, typ, adr, ok);
      exp_a = (exp_t[i] == 2'b10) ? 22'h000100 : 22'h000208;
      checks++;
      if (!ok || typ !== exp_t[i] || adr !== exp_a) begin
        fails++;
        $display("FAIL rr_order[%0d]: ok=%b type=%b addr=%h, expected type=%b addr=%h",
                 i, ok, typ, adr, exp_t[i], exp_a);
      end
      checks++;
      if (WR_BURST_DONE !== (exp_t[i] == 2'b10) || RD_BURST_DONE !== (exp_t[i] == 2'b11)) begin
        fails++;
        $display("FAIL rr_done[%0d]: wrd=%b rdd=%b, expected %b/%b", i,
                 WR_BURST_DONE, RD_BURST_DONE, exp_t[i] == 2'b10, exp_t[i] == 2'b11);
      end
    end
    WR_REQ = 1'b0; RD_REQ = 1'b0;
  endtask

  task automatic test_refresh_priority();
    int t0, nref, nother, dly;
    bit ok;
    logic [1:0] typ;
    logic [ADDR_W-1:0] adr;
    do_init(t0);
    WR_REQ = 1'b1; RD_REQ = 1'b1;
    WR_ADDR = 22'h000040; RD_ADDR = 22'h0000C7;
    serve(800, 20, typ, adr, ok);
    WR_REQ = 1'b0;
    checks++;
    if (!ok || typ !== 2'b10 || adr !== 22'h000040) begin
      fails++;
      $display("FAIL ref_first_write: ok=%b type=%b addr=%h, expected 10/000040", ok, typ, adr);
    end
    serve(2, 20, typ, adr, ok);
    checks++;
    if (!ok || typ !== 2'b01 || adr !== 22'h000000) begin
      fails++;
      $display("FAIL ref_priority: ok=%b type=%b addr=%h, expected 01/000000", ok, typ, adr);
    end
    serve(2, 20, typ, adr, ok);
    RD_REQ = 1'b0;
    checks++;
    if (!ok || typ !== 2'b11 || adr !== 22'h0000C0) begin
      fails++;
      $display("FAIL ref_then_read: ok=%b type=%b addr=%h, expected 11/0000C0", ok, typ, adr);
    end
    nref = 0; nother = 0; dly = 0;
    CMD_READY = 1'b1;
    for (int i = 0; i < 7800; i++) begin
      CMD_DONE = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) CMD_DONE = 1'b1;
      end
      if (CMD_VALID) begin
        if (CMD_TYPE == 2'b01) nref++;
        else nother++;
        dly = 2;
      end
      step();
    end
    CMD_DONE = 1'b0; CMD_READY = 1'b0;
    checks++;
    if (nref !== 10 || nother !== 0 || REF_OVERRUN !== 1'b0) begin
      fails++;
      $display("FAIL ref_period: refreshes=%0d others=%0d ovr=%b, expected 10/0/0",
               nref, nother, REF_OVERRUN);
    end
  endtask

  task automatic test_overrun();
    int t0;
    bit ok;
    logic [1:0] typ;
    logic [ADDR_W-1:0] adr;
    do_init(t0);
    while (cyc < t0 + 3119) step();
    checks++;
    if (REF_OVERRUN !== 1'b0 || CMD_VALID !== 1'b1 || CMD_TYPE !== 2'b01) begin
      fails++;
      $display("FAIL ovr_before_4th: ovr=%b valid=%b type=%b, expected 0/1/01",
               REF_OVERRUN, CMD_VALID, CMD_TYPE);
    end
    step();
    checks++;
    if (REF_OVERRUN !== 1'b1) begin
      fails++;
      $display("FAIL ovr_on_4th: ovr=%b, expected 1", REF_OVERRUN);
    end
    for (int i = 0; i < 3; i++) begin
      serve(2, 5, typ, adr, ok);
      checks++;
      if (!ok || typ !== 2'b01 || adr !== 22'h000000) begin
        fails++;
        $display("FAIL ovr_refresh[%0d]: ok=%b type=%b addr=%h, expected 01/000000", i, ok, typ, adr);
      end
    end
    repeat (5) step();
    checks++;
    if (CMD_VALID !== 1'b0 || REF_OVERRUN !== 1'b1) begin
      fails++;
      $display("FAIL ovr_drained: valid=%b ovr=%b, expected 0/1", CMD_VALID, REF_OVERRUN);
    end
  endtask

  task automatic test_backpressure_reset();
    int t0, changes, active;
    do_init(t0);
    WR_REQ = 1'b1; WR_ADDR = 22'h0003A5;
    step();
    checks++;
    if (CMD_VALID !== 1'b1 || CMD_TYPE !== 2'b10 || CMD_ADDR !== 22'h0003A0) begin
      fails++;
      $display("FAIL bp_issue: valid=%b type=%b addr=%h, expected 1/10/0003A0",
               CMD_VALID, CMD_TYPE, CMD_ADDR);
    end
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        WR_REQ = 1'b0; WR_ADDR = 22'h01FFFF;
      end
      step();
      if (CMD_VALID !== 1'b1 || CMD_TYPE !== 2'b10 || CMD_ADDR !== 22'h0003A0) changes++;
    end
    checks++;
    if (changes !== 0) begin
      fails++;
      $display("FAIL bp_hold: %0d cycles changed, expected 0", changes);
    end
    CMD_READY = 1'b1;
    step();
    CMD_READY = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || CMD_VALID !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: busy=%b valid=%b, expected 1/0", BUSY, CMD_VALID);
    end
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if ({CMD_VALID, CMD_TYPE, CMD_ADDR, BUSY, WR_BURST_DONE, RD_BURST_DONE, REF_OVERRUN} !== '0) begin
      fails++;
      $display("FAIL rst_mid_cmd: valid=%b type=%b addr=%h busy=%b wrd=%b rdd=%b ovr=%b, expected all 0",
               CMD_VALID, CMD_TYPE, CMD_ADDR, BUSY, WR_BURST_DONE, RD_BURST_DONE, REF_OVERRUN);
    end
    step();
    CMD_DONE = 1'b1;
    step();
    CMD_DONE = 1'b0;
    active = 0;
    repeat (4) begin
      if (WR_BURST_DONE || RD_BURST_DONE || BUSY || CMD_VALID) active++;
      step();
    end
    checks++;
    if (active !== 0) begin
      fails++;
      $display("FAIL rst_stray_done: %0d active cycles, expected 0", active);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_round_robin();
    test_refresh_priority();
    test_overrun();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
